// File: rtl/long_div_core.sv
// -----------------------------------------------------------------------------
// long_div_core
//
// Bit-serial modular reduction for the RSA datapath. Computes
//   ld_out = (num_in * 2^len) mod modulus
// which maps an operand into the Montgomery domain with R = 2^len.
// One shift-and-subtract step is performed per clock.
//
// Build option:
//   LONG_DIV_PRE_REDUCE_EN  defined   -> 32-cycle DIV phase reduces any num_in
//                                        first; latency 33+len cycles.
//                           undefined -> DIV phase omitted, r starts at num_in;
//                                        latency 1+len cycles; the caller must
//                                        keep num_in < modulus.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rstn      in   1   asynchronous active-low reset
//   md_start  in   1   start request, honoured only while idle
//   len       in   8   shift exponent (R = 2^len)
//   num_in    in  32   operand, unsigned
//   modulus   in  32   modulus N, unsigned
//   md_end    out  1   one-cycle completion pulse
//   ld_out    out 32   result, held until the next completion
// -----------------------------------------------------------------------------
module long_div_core (
  input  logic        clk,
  input  logic        rstn,
  input  logic        md_start,
  input  logic [7:0]  len,
  input  logic [31:0] num_in,
  input  logic [31:0] modulus,
  output logic        md_end,
  output logic [31:0] ld_out
);

  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [DATA_W:0]     r;          // 33-bit remainder, r < N after every step
  logic [DATA_W-1:0]   mod_q;      // latched modulus
  logic [LEN_W-1:0]    shift_cnt;  // remaining doubling steps
`ifdef LONG_DIV_PRE_REDUCE_EN
  logic [DATA_W-1:0]   num_q;      // latched operand, consumed MSB first
  logic [LEN_W-1:0]    len_q;      // latched exponent, needed at end of DIV
  logic [4:0]          bit_cnt;    // operand bit being shifted in
`endif

  // One conditional-subtract step: t is the already-shifted 33-bit value.
  // Since r < N < 2^32 before the shift, a single subtraction restores r < N.
  function automatic logic [DATA_W:0] mod_step(input logic [DATA_W:0]   t,
                                               input logic [DATA_W-1:0] n);
    logic [DATA_W:0] n_ext;
    n_ext = {1'b0, n};
    if (t >= n_ext) begin
      mod_step = t - n_ext;
    end else begin
      mod_step = t;
    end
  endfunction

  // Doubling with an optional incoming bit; shifting the full 33-bit r keeps
  // the width arithmetic explicit (the top bit is always zero here).
  function automatic logic [DATA_W:0] shift_in(input logic [DATA_W:0] rv,
                                               input logic            b);
    shift_in = (rv << 1) | {{DATA_W{1'b0}}, b};
  endfunction

  // A zero modulus yields zero by definition; the step arithmetic alone would
  // just pass the value through, so it is forced at completion.
  function automatic logic [DATA_W-1:0] final_value(input logic [DATA_W:0]   rv,
                                                    input logic [DATA_W-1:0] n);
    if (n == '0) begin
      final_value = '0;
    end else begin
      final_value = rv[DATA_W-1:0];
    end
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      r         <= '0;
      mod_q     <= '0;
      shift_cnt <= '0;
      md_end    <= 1'b0;
      ld_out    <= '0;
`ifdef LONG_DIV_PRE_REDUCE_EN
      num_q     <= '0;
      len_q     <= '0;
      bit_cnt   <= '0;
`endif
    end else begin
      md_end <= 1'b0;

      case (state)
        // ---- IDLE: capture operands so later input changes are ignored ----
        IDLE: begin
          if (md_start) begin
            mod_q     <= modulus;
            shift_cnt <= len;
`ifdef LONG_DIV_PRE_REDUCE_EN
            num_q     <= num_in;
            len_q     <= len;
            bit_cnt   <= 5'd31;
            r         <= '0;
            state     <= DIV;
`else
            // Caller guarantees num_in < modulus, so it is already reduced.
            r         <= {1'b0, num_in};
            state     <= (len == '0) ? DONE : SHIFT;
`endif
          end
        end

`ifdef LONG_DIV_PRE_REDUCE_EN
        // ---- DIV: long division of num by N, MSB first, 32 cycles ----
        DIV: begin
          r <= mod_step(shift_in(r, num_q[bit_cnt]), mod_q);
          if (bit_cnt == 5'd0) begin
            state <= (len_q == '0) ? DONE : SHIFT;
          end else begin
            bit_cnt <= bit_cnt - 5'd1;
          end
        end
`endif

        // ---- SHIFT: multiply by 2 mod N, len cycles ----
        SHIFT: begin
          r         <= mod_step(shift_in(r, 1'b0), mod_q);
          shift_cnt <= shift_cnt - 8'd1;
          if (shift_cnt == 8'd1) begin
            state <= DONE;
          end
        end

        // ---- DONE: publish result and pulse md_end ----
        DONE: begin
          ld_out <= final_value(r, mod_q);
          md_end <= 1'b1;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_long_div_core.sv
// -----------------------------------------------------------------------------
// tb_long_div_core
//
// Directed bench for long_div_core: reset state, reference vectors, latency,
// input isolation, zero/unit modulus, busy-start rejection, mid-run reset,
// back-to-back and held-start operation. Expected results are hand-computed.
// -----------------------------------------------------------------------------
module tb_long_div_core;

`ifdef LONG_DIV_PRE_REDUCE_EN
  localparam int PRE = 32;
`else
  localparam int PRE = 0;
`endif

  logic        clk;
  logic        rstn;
  logic        md_start;
  logic [7:0]  len;
  logic [31:0] num_in;
  logic [31:0] modulus;
  logic        md_end;
  logic [31:0] ld_out;

  int checks = 0;
  int errors = 0;
  int cyc;
  int pulses;

  long_div_core dut (
    .clk      (clk),
    .rstn     (rstn),
    .md_start (md_start),
    .len      (len),
    .num_in   (num_in),
    .modulus  (modulus),
    .md_end   (md_end),
    .ld_out   (ld_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(input int l);
    return PRE + 1 + l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Presents operands and a single-cycle md_start; returns #1 after start edge.
  task automatic start_op(input logic [31:0] n, input logic [7:0] l, input logic [31:0] m);
    @(negedge clk);
    num_in   = n;
    len      = l;
    modulus  = m;
    md_start = 1'b1;
    @(posedge clk);
    #1 md_start = 1'b0;
  endtask

  // Counts edges until md_end is seen high (bounded).
  task automatic wait_done(output int c);
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!md_end && c < 400);
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (md_end) p++;
    end
  endtask

  initial begin
    rstn     = 1'b0;
    md_start = 1'b0;
    len      = '0;
    num_in   = '0;
    modulus  = '0;

    // Reset state
    #1;
    chk("reset_md_end", {31'd0, md_end}, 32'd0);
    chk("reset_ld_out", ld_out, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Reference vector: 12345 * 2^27 mod 128255609
    start_op(32'd12345, 8'd27, 32'd128255609);
    wait_done(cyc);
    chk("ref_latency", cyc, lat(27));
    chk("ref_result", ld_out, 32'd111895098);
    @(posedge clk);
    #1;
    chk("ref_end_falls", {31'd0, md_end}, 32'd0);
    chk("ref_ld_hold", ld_out, 32'd111895098);

    // len = 0
`ifdef LONG_DIV_PRE_REDUCE_EN
    start_op(32'hFFFF_FFFF, 8'd0, 32'd1000);
    wait_done(cyc);
    chk("len0_latency", cyc, lat(0));
    chk("len0_result", ld_out, 32'd295);
`else
    start_op(32'd999, 8'd0, 32'd1000);
    wait_done(cyc);
    chk("len0_latency", cyc, lat(0));
    chk("len0_result", ld_out, 32'd999);
`endif

    // Inputs changed right after start must not matter: 5*8 mod 7 = 5
    start_op(32'd5, 8'd3, 32'd7);
    num_in  = 32'd100;
    len     = 8'd9;
    modulus = 32'd11;
    wait_done(cyc);
    chk("iso_latency", cyc, lat(3));
    chk("iso_result", ld_out, 32'd5);

    // Zero modulus: result 0, one pulse, normal latency
    start_op(32'd77, 8'd5, 32'd0);
    wait_done(cyc);
    chk("mod0_latency", cyc, lat(5));
    chk("mod0_result", ld_out, 32'd0);
    count_pulses(40, pulses);
    chk("mod0_single_pulse", pulses, 0);

    // Unit modulus
`ifdef LONG_DIV_PRE_REDUCE_EN
    start_op(32'd9, 8'd4, 32'd1);
`else
    start_op(32'd0, 8'd4, 32'd1);
`endif
    wait_done(cyc);
    chk("mod1_result", ld_out, 32'd0);

    // md_start toggled while busy: one completion only. 200*1024 mod 1009 = 982
    start_op(32'd200, 8'd10, 32'd1009);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      md_start = ~md_start;
      num_in   = 32'd1 + i;
    end
    @(negedge clk);
    md_start = 1'b0;
    count_pulses(lat(10) + 40, pulses);
    chk("busy_pulses", pulses, 1);
    chk("busy_result", ld_out, 32'd982);

    // Reset mid-operation: immediate clear, no pulse afterwards
    start_op(32'd12345, 8'd27, 32'd128255609);
    repeat (10) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("abort_md_end", {31'd0, md_end}, 32'd0);
    chk("abort_ld_out", ld_out, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    count_pulses(100, pulses);
    chk("abort_no_pulse", pulses, 0);

    // Back-to-back: 2^32 mod (2^32-5) = 5, then 3*5 = 15 restarted during md_end
    start_op(32'd1, 8'd32, 32'hFFFF_FFFB);
    wait_done(cyc);
    chk("b2b_first_latency", cyc, lat(32));
    chk("b2b_first_result", ld_out, 32'd5);
    num_in   = 32'd3;
    md_start = 1'b1;
    @(posedge clk);
    #1 md_start = 1'b0;
    chk("b2b_end_falls", {31'd0, md_end}, 32'd0);
    wait_done(cyc);
    chk("b2b_second_latency", cyc, lat(32));
    chk("b2b_second_result", ld_out, 32'd15);

    // md_start held high: restart on first edge back in IDLE
    @(negedge clk);
    num_in   = 32'd5;
    len      = 8'd3;
    modulus  = 32'd7;
    md_start = 1'b1;
    wait_done(cyc);
    chk("held_first_result", ld_out, 32'd5);
    num_in = 32'd6;
    wait_done(cyc);
    md_start = 1'b0;
    chk("held_restart_gap", cyc, lat(3) + 1);
    chk("held_second_result", ld_out, 32'd6);  // 6*8 mod 7 = 6

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/long_div_core.md
# long_div_core

Sequential modular-reduction block for the RSA datapath: computes ld_out = (num_in · 2^len) mod modulus, which converts an operand into the Montgomery domain (R = 2^len). It uses a bit-serial shift-and-subtract long division, one bit per clock. The RSA top-level controller starts it with md_start and collects the result on md_end.

## Interface
- No parameters. Data width is fixed at 32 bits; len is 8 bits.
- clk  input  1  system clock, rising-edge active.
- rstn  input  1  reset. Asynchronous, active-low.
- md_start  input  1  start request, sampled on the clock edge, honoured only in IDLE.
- len  input  8  shift exponent (Montgomery R = 2^len), 0..255.
- num_in  input  32  operand, unsigned.
- modulus  input  32  modulus N, unsigned.
- md_end  output  1  one-cycle done pulse.
- ld_out  output  32  result, held until the next completion.

## Operation
- States:
  - IDLE: waits for md_start.
  - DIV: pre-reduction, 32 cycles.
  - SHIFT: doubling, len cycles.
  - DONE: 1 cycle.
- IDLE with md_start=1 at an edge:
  - Latch num_in, len and modulus into internal registers.
  - Clear the 33-bit remainder r to 0 and set the bit counter to 31.
  - Go to DIV.
- DIV, one step per cycle, from bit 31 down to bit 0: t = 2r + num[bit]; if t ≥ N then r = t − N, else r = t. After bit 0, r = num_in mod N.
- SHIFT, one step per cycle, len times: t = 2r; if t ≥ N then r = t − N, else r = t.
  - If len = 0, go from DIV directly to DONE.
- DONE: ld_out ← r[31:0], md_end ← 1, next state IDLE.
- Arithmetic rules:
  - The intermediate t is 33 bits wide.
  - Compare and subtract are unsigned.
  - Invariant r < N holds after every step.
- modulus = 0: ld_out = 0, with normal latency and a normal md_end pulse.
- modulus = 1: result is 0.
- Inputs are don't-care after the start edge; later changes must not affect the result.
- md_start while busy (not IDLE): ignored, with no restart and no queueing.
- md_start held high continuously: a new operation starts on the first edge back in IDLE.

## Timing
- Reset (asynchronous, rstn=0): state = IDLE, md_end = 0, ld_out = 0, r = 0, counters = 0.
- Start accepted at edge T0. Then:
  - DIV occupies edges T0+1 .. T0+32.
  - SHIFT occupies edges T0+33 .. T0+32+len.
  - The edge at T0+33+len registers ld_out and raises md_end.
- md_end is high for exactly one cycle; it falls at edge T0+34+len.
- Total latency is 33+len cycles from the start edge to md_end rising. Worst case is 288 cycles.
- ld_out changes only at the DONE edge or on reset.
- rstn asserted mid-operation: immediate abort to reset values, with no md_end.
- Earliest next start is the edge after DONE, i.e. while md_end is high.

## Configuration
- Macro: LONG_DIV_PRE_REDUCE_EN.
- Defined (default build):
  - Full 32-cycle DIV phase.
  - Any num_in is legal.
  - Latency 33+len.
- Undefined:
  - The DIV phase is omitted and r is loaded with num_in at the start edge.
  - Latency is 1+len cycles (md_end rises at edge T0+1+len).
  - The caller must guarantee num_in < modulus; otherwise the result is undefined.

## Test plan
- num_in=12345, len=27, modulus=128255609; md_start pulsed one cycle after reset release -> md_end after 60 cycles (default build); ld_out = 111895098.
- num_in=0xFFFFFFFF, len=0, modulus=1000 -> ld_out = 295 (4294967295 mod 1000); latency 33.
- num_in=5, len=3, modulus=7 -> ld_out = 5 (40 mod 7). Change the inputs during the operation -> result unchanged.
- modulus=0 with any num_in and len -> ld_out = 0, and md_end pulses once.
- Assert md_start repeatedly while busy -> exactly one md_end pulse. Assert rstn low mid-DIV -> md_end and ld_out read 0 immediately, and no pulse follows.
- Back-to-back operations: num_in=1, len=32, modulus=0xFFFFFFFB -> ld_out = 5; then restart during the md_end cycle with num_in=3 -> ld_out = 15.
